serial_rx: RTL

- UART receiver, 8N1, LSB first. Samples asynchronous serial line `i_rx` at mid-bit and delivers each complete byte as a one-cycle strobe.
- Receive-side counterpart to the existing serial transmit path in the Fomu uart design.
- Bit timing comes from an instance of the existing `countdown` timer.
- Sits between the pad input and the byte consumer (loopback or FIFO).

---
 rtl/serial_rx_pkg.sv | 16 +
 rtl/countdown.sv | 21 ++
 rtl/serial_rx.sv | 132 +++++++++++++
 3 files changed

// File: rtl/serial_rx_pkg.sv
// Shared UART receive definitions: default bit timing, frame width and FSM states.
package serial_rx_pkg;

  // 48 MHz / 115200 baud, rounded to the nearest clock.
  localparam int unsigned DEFAULT_BAUD_DIV = 417;
  localparam int unsigned DATA_BITS        = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BRK
  } state_t;

endpackage

// File: rtl/countdown.sv
// Loadable down-counter used as the UART bit timer.
module countdown #(
  parameter int unsigned INIT = 0,
  parameter int unsigned BITS = 8
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_wr,
  input  logic [BITS-1:0] i_data,
  input  logic            i_en,
  output logic [BITS-1:0] o_count
);

  // Load has priority over the decrement.
  always_ff @(posedge i_clk) begin
    if (i_rst)     o_count <= BITS'(INIT);
    else if (i_wr) o_count <= i_data;
    else if (i_en) o_count <= o_count - 1'b1;
  end

endmodule

// File: rtl/serial_rx.sv
// 8N1 UART receiver: mid-bit sampling of a synchronised line, LSB first,
// one-cycle strobes for a received byte or a framing error.
module serial_rx
  import serial_rx_pkg::*;
#(
  parameter int unsigned BAUD_DIV = DEFAULT_BAUD_DIV,
  parameter int unsigned BITS     = $clog2(BAUD_DIV)
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_rx,
  output logic       o_wr,
  output logic [7:0] o_data,
  output logic       o_err,
  output logic       o_busy
);

  localparam logic [BITS-1:0] HALF_LOAD = BITS'(BAUD_DIV / 2 - 1);
  localparam logic [BITS-1:0] FULL_LOAD = BITS'(BAUD_DIV - 1);
  localparam logic [2:0]      LAST_BIT  = 3'(DATA_BITS - 1);

  state_t                 state;
  logic                   sync1;
  logic                   rx_s;
  logic [DATA_BITS-1:0]   shift;
  logic [2:0]             bit_cnt;
  logic [BITS-1:0]        tmr_count;
  logic [BITS-1:0]        tmr_val;
  logic                   tmr_wr;
  logic                   tmr_en;
  logic                   timed;
  logic                   tick;

  // Two-flop synchroniser, idling at the line's mark level.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sync1 <= 1'b1;
      rx_s  <= 1'b1;
    end else begin
      sync1 <= i_rx;
      rx_s  <= sync1;
    end
  end

  countdown #(
    .INIT(0),
    .BITS(BITS)
  ) u_timer (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_wr   (tmr_wr),
    .i_data (tmr_val),
    .i_en   (tmr_en),
    .o_count(tmr_count)
  );

  // Timer control: half-bit load on start edge, full-bit reloads until the stop sample.
  always_comb begin
    timed   = (state == S_START) || (state == S_DATA) || (state == S_STOP);
    tick    = timed && (tmr_count == '0);
    tmr_en  = timed;
    tmr_wr  = 1'b0;
    tmr_val = FULL_LOAD;
    case (state)
      S_IDLE: begin
        if (!rx_s) begin
          tmr_wr  = 1'b1;
          tmr_val = HALF_LOAD;
        end
      end
      S_START: tmr_wr = tick && !rx_s;
      S_DATA:  tmr_wr = tick;
      default: ;
    endcase
  end

  // Frame FSM with registered strobes and output byte.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state   <= S_IDLE;
      o_wr    <= 1'b0;
      o_err   <= 1'b0;
      o_data  <= '0;
      shift   <= '0;
      bit_cnt <= '0;
    end else begin
      o_wr  <= 1'b0;
      o_err <= 1'b0;
      case (state)
        S_IDLE: begin
          if (!rx_s) state <= S_START;
        end
        S_START: begin
          if (tick) begin
            if (!rx_s) begin
              bit_cnt <= '0;
              state   <= S_DATA;
            end else begin
              state <= S_IDLE;
            end
          end
        end
        S_DATA: begin
          if (tick) begin
            shift   <= {rx_s, shift[DATA_BITS-1:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == LAST_BIT) state <= S_STOP;
          end
        end
        S_STOP: begin
          if (tick) begin
            if (rx_s) begin
              o_data <= shift;
              o_wr   <= 1'b1;
              state  <= S_IDLE;
            end else begin
              o_err <= 1'b1;
              state <= S_BRK;
            end
          end
        end
        S_BRK: begin
          if (rx_s) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign o_busy = (state != S_IDLE);

endmodule
